// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-port register file with write bypass and busy scoreboard
module regfile_mp_sb #(
    parameter int REG_WIDTH = 32,
    parameter int NUM_REG   = 32,
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 2,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG  = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_WR-1:0]                     wr_en,
    input  logic [NUM_WR*$clog2(NUM_REG)-1:0]     wr_addr,
    input  logic [NUM_WR*REG_WIDTH-1:0]           wr_data,
    input  logic [NUM_RD*$clog2(NUM_REG)-1:0]     rd_addr,
    output logic [NUM_RD*REG_WIDTH-1:0]           rd_data,
    output logic [NUM_RD-1:0]                     rd_busy,
    input  logic                                  rsv_en,
    input  logic [$clog2(NUM_REG)-1:0]            rsv_addr,
    input  logic                                  flush,
    output logic [$clog2(NUM_REG+1)-1:0]          busy_cnt
);

    localparam int AW = $clog2(NUM_REG);
    localparam int CW = $clog2(NUM_REG+1);

    logic [REG_WIDTH-1:0] regs_q [NUM_REG];
    logic [REG_WIDTH-1:0] regs_d [NUM_REG];
    logic [NUM_REG-1:0]   busy_q, busy_d;
    logic [CW-1:0]        busy_cnt_q, busy_cnt_d;

    logic [AW-1:0]        rd_idx;
    logic [REG_WIDTH-1:0] rd_val;
    logic                 rd_hit;
    logic                 rd_bsy;

    // Ascending port order lets the highest-index write win on address collisions.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_en[i]) begin
                regs_d[wr_addr[i*AW +: AW]] = wr_data[i*REG_WIDTH +: REG_WIDTH];
                busy_d[wr_addr[i*AW +: AW]] = 1'b0;
            end
        end
        if (rsv_en) begin
            busy_d[rsv_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        if (ZERO_REG != 0) begin
            regs_d[0] = '0;
            busy_d[0] = 1'b0;
        end
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int r = 0; r < NUM_REG; r++) begin
            busy_cnt_d = busy_cnt_d + CW'(busy_d[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REG; r++) begin
                regs_q[r] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // A same-cycle reserve to the read register marks a younger producer, so it stays busy.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        rd_idx  = '0;
        rd_val  = '0;
        rd_hit  = 1'b0;
        rd_bsy  = 1'b0;
        for (int j = 0; j < NUM_RD; j++) begin
            rd_idx = rd_addr[j*AW +: AW];
            rd_val = regs_q[rd_idx];
            rd_bsy = busy_q[rd_idx];
            rd_hit = 1'b0;
            if (BYPASS != 0) begin
                for (int i = 0; i < NUM_WR; i++) begin
                    if (wr_en[i] && wr_addr[i*AW +: AW] == rd_idx) begin
                        rd_val = wr_data[i*REG_WIDTH +: REG_WIDTH];
                        rd_hit = 1'b1;
                    end
                end
                if (rd_hit && !(rsv_en && rsv_addr == rd_idx)) begin
                    rd_bsy = 1'b0;
                end
            end
            if (ZERO_REG != 0 && rd_idx == '0) begin
                rd_val = '0;
                rd_bsy = 1'b0;
            end
            rd_data[j*REG_WIDTH +: REG_WIDTH] = rd_val;
            rd_busy[j]                        = rd_bsy;
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb/tb_regfile_mp_sb.sv - directed and randomized checks of regfile_mp_sb (bypass and non-bypass builds)
module tb_regfile_mp_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  s_wr_en;
    logic [4:0]  s_wr_addr [4];
    logic [31:0] s_wr_data [4];
    logic [4:0]  s_rd_addr [3];
    logic        s_rsv_en;
    logic [4:0]  s_rsv_addr;
    logic        s_flush;

    logic [95:0] rd_data_a, rd_data_b;
    logic [2:0]  rd_busy_a, rd_busy_b;
    logic [5:0]  busy_cnt_a, busy_cnt_b;

    int vectors    = 0;
    int miscompares = 0;

    // Reference state: index 0 = 2-write bypass build, index 1 = 4-write non-bypass build.
    logic [31:0] m_regs [2][32];
    bit          m_busy [2][32];

    always #5 clk = ~clk;

    regfile_mp_sb #(.REG_WIDTH(32), .NUM_REG(32), .NUM_RD(3), .NUM_WR(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst),
        .wr_en(s_wr_en[1:0]),
        .wr_addr({s_wr_addr[1], s_wr_addr[0]}),
        .wr_data({s_wr_data[1], s_wr_data[0]}),
        .rd_addr({s_rd_addr[2], s_rd_addr[1], s_rd_addr[0]}),
        .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .rsv_en(s_rsv_en), .rsv_addr(s_rsv_addr), .flush(s_flush),
        .busy_cnt(busy_cnt_a)
    );

    regfile_mp_sb #(.REG_WIDTH(32), .NUM_REG(32), .NUM_RD(3), .NUM_WR(4), .BYPASS(0), .ZERO_REG(1)) dut_b (
        .clk(clk), .rst(rst),
        .wr_en(s_wr_en),
        .wr_addr({s_wr_addr[3], s_wr_addr[2], s_wr_addr[1], s_wr_addr[0]}),
        .wr_data({s_wr_data[3], s_wr_data[2], s_wr_data[1], s_wr_data[0]}),
        .rd_addr({s_rd_addr[2], s_rd_addr[1], s_rd_addr[0]}),
        .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .rsv_en(s_rsv_en), .rsv_addr(s_rsv_addr), .flush(s_flush),
        .busy_cnt(busy_cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dut_data(input int k, input int j);
        return (k == 0) ? rd_data_a[j*32 +: 32] : rd_data_b[j*32 +: 32];
    endfunction

    function automatic logic dut_busy(input int k, input int j);
        return (k == 0) ? rd_busy_a[j] : rd_busy_b[j];
    endfunction

    function automatic logic [31:0] dut_cnt(input int k);
        return (k == 0) ? 32'(busy_cnt_a) : 32'(busy_cnt_b);
    endfunction

    function automatic int n_wr(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    // What a read port should show right now, given stored state and this cycle's inputs.
    function automatic logic [31:0] exp_data(input int k, input int j);
        logic [31:0] v;
        int a = int'(s_rd_addr[j]);
        if (a == 0) return 32'h0;
        v = m_regs[k][a];
        if (k == 0)
            for (int i = 0; i < n_wr(k); i++)
                if (s_wr_en[i] && int'(s_wr_addr[i]) == a) v = s_wr_data[i];
        return v;
    endfunction

    function automatic logic exp_busy(input int k, input int j);
        bit written = 0;
        int a = int'(s_rd_addr[j]);
        if (a == 0) return 1'b0;
        for (int i = 0; i < n_wr(k); i++)
            if (s_wr_en[i] && int'(s_wr_addr[i]) == a) written = 1;
        if (k == 0 && written && !(s_rsv_en && int'(s_rsv_addr) == a)) return 1'b0;
        return m_busy[k][a];
    endfunction

    function automatic logic [31:0] exp_cnt(input int k);
        int n = 0;
        foreach (m_busy[k][r]) n += int'(m_busy[k][r]);
        return 32'(n);
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                for (int r = 0; r < 32; r++) begin
                    m_regs[k][r] = 32'h0;
                    m_busy[k][r] = 0;
                end
            end else begin
                for (int r = 1; r < 32; r++) begin
                    bit written = 0;
                    for (int i = 0; i < n_wr(k); i++)
                        if (s_wr_en[i] && int'(s_wr_addr[i]) == r) begin
                            written = 1;
                            m_regs[k][r] = s_wr_data[i];
                        end
                    if (s_flush)                              m_busy[k][r] = 0;
                    else if (s_rsv_en && int'(s_rsv_addr) == r) m_busy[k][r] = 1;
                    else if (written)                         m_busy[k][r] = 0;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        s_wr_en = '0; s_rsv_en = 1'b0; s_flush = 1'b0;
        for (int i = 0; i < 4; i++) begin s_wr_addr[i] = '0; s_wr_data[i] = '0; end
        s_rsv_addr = '0;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        for (int j = 0; j < 3; j++) s_rd_addr[j] = '0;
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b1;

        // 1: reset state on every address and port
        for (int a = 0; a < 32; a++) begin
            for (int j = 0; j < 3; j++) s_rd_addr[j] = 5'(a);
            #1;
            for (int j = 0; j < 3; j++) begin
                chk("rst_data", dut_data(0, j), 32'h0);
                chk("rst_busy", 32'(dut_busy(0, j)), 32'h0);
            end
        end
        chk("rst_cnt", dut_cnt(0), 32'h0);

        // 2: colliding writes, highest port wins
        s_wr_en = 4'b0011;
        s_wr_addr[0] = 5'd5; s_wr_data[0] = 32'hDEAD_BEEF;
        s_wr_addr[1] = 5'd5; s_wr_data[1] = 32'h1234_5678;
        s_rd_addr[0] = 5'd5;
        #1 chk("wr_bypass", dut_data(0, 0), 32'h1234_5678);
        cycle();
        idle();
        #1 chk("wr_stored", dut_data(0, 0), 32'h1234_5678);

        // 3: reserve then write clears busy with bypass
        s_rsv_en = 1'b1; s_rsv_addr = 5'd7;
        cycle();
        idle();
        s_rd_addr[0] = 5'd7;
        #1 chk("rsv_busy", 32'(rd_busy_a[0]), 32'h1);
        chk("rsv_cnt", dut_cnt(0), 32'h1);
        s_wr_en = 4'b0001; s_wr_addr[0] = 5'd7; s_wr_data[0] = 32'h55;
        #1 chk("wb_data", dut_data(0, 0), 32'h55);
        chk("wb_busy", 32'(rd_busy_a[0]), 32'h0);
        cycle();
        idle();
        chk("wb_cnt", dut_cnt(0), 32'h0);

        // 4: reserve beats same-cycle write
        s_rsv_en = 1'b1; s_rsv_addr = 5'd9;
        s_wr_en = 4'b0001; s_wr_addr[0] = 5'd9; s_wr_data[0] = 32'hAA;
        s_rd_addr[1] = 5'd9;
        #1 chk("rw_same_busy", 32'(rd_busy_a[1]), 32'h0);
        cycle();
        idle();
        #1 chk("rw_busy", 32'(rd_busy_a[1]), 32'h1);
        chk("rw_data", dut_data(0, 1), 32'hAA);

        // 5: successive reserves, then flush overrides a same-cycle reserve
        for (int a = 1; a <= 3; a++) begin
            s_rsv_en = 1'b1; s_rsv_addr = 5'(a);
            cycle();
        end
        idle();
        chk("pre_flush_cnt", dut_cnt(0), 32'd4);
        s_flush = 1'b1; s_rsv_en = 1'b1; s_rsv_addr = 5'd4;
        cycle();
        idle();
        chk("flush_cnt", dut_cnt(0), 32'h0);
        for (int a = 1; a <= 9; a++) begin
            s_rd_addr[2] = 5'(a);
            #1 chk("flush_busy", 32'(rd_busy_a[2]), 32'h0);
        end

        // 6: register 0 ignores writes and reserves
        s_wr_en = 4'b0011; s_wr_addr[0] = 5'd0; s_wr_addr[1] = 5'd0;
        s_wr_data[0] = 32'hFFFF_FFFF; s_wr_data[1] = 32'hFFFF_FFFF;
        s_rsv_en = 1'b1; s_rsv_addr = 5'd0;
        s_rd_addr[0] = 5'd0;
        #1 chk("z_data_byp", dut_data(0, 0), 32'h0);
        cycle();
        idle();
        #1 chk("z_data", dut_data(0, 0), 32'h0);
        chk("z_busy", 32'(rd_busy_a[0]), 32'h0);
        chk("z_cnt", dut_cnt(0), 32'h0);

        // 7: reset mid-operation discards that cycle's write and reserve
        s_wr_en = 4'b0001; s_wr_addr[0] = 5'd12; s_wr_data[0] = 32'hCAFE;
        s_rsv_en = 1'b1; s_rsv_addr = 5'd13;
        rst = 1'b0;
        cycle();
        idle();
        rst = 1'b1;
        s_rd_addr[0] = 5'd12; s_rd_addr[1] = 5'd13; s_rd_addr[2] = 5'd5;
        #1 chk("mid_rst_data", dut_data(0, 0), 32'h0);
        chk("mid_rst_busy", 32'(rd_busy_a[1]), 32'h0);
        chk("mid_rst_old", dut_data(0, 2), 32'h0);
        chk("mid_rst_cnt", dut_cnt(0), 32'h0);

        // Random traffic on both builds against the reference model
        for (int n = 0; n < 600; n++) begin
            s_wr_en = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                s_wr_addr[i] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
                s_wr_data[i] = $urandom;
            end
            for (int j = 0; j < 3; j++)
                s_rd_addr[j] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            s_rsv_en   = 1'($urandom);
            s_rsv_addr = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            s_flush    = ($urandom_range(0, 15) == 0);
            rst        = ($urandom_range(0, 63) != 0);
            #1;
            for (int k = 0; k < 2; k++)
                for (int j = 0; j < 3; j++) begin
                    chk($sformatf("rnd_data k%0d p%0d n%0d", k, j, n), dut_data(k, j), exp_data(k, j));
                    chk($sformatf("rnd_busy k%0d p%0d n%0d", k, j, n), 32'(dut_busy(k, j)), 32'(exp_busy(k, j)));
                end
            cycle();
            for (int k = 0; k < 2; k++)
                chk($sformatf("rnd_cnt k%0d n%0d", k, n), dut_cnt(k), exp_cnt(k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
